// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Pipeline hazard and stall controller for the five-stage in-order RISC-V
// core. It sits beside the stage registers and decides, every cycle, which
// stage registers hold, which ones receive a bubble, and which DECODE
// operands take a forwarded result from EXE or MEM.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   id_valid              DECODE holds a valid instruction
//   id_src1, id_src2      DECODE source register indices
//   id_uses_src2          src2 is a real register operand
//   ex_valid, ex_wen      EXE instruction valid / writes a register
//   ex_is_load, ex_is_mul EXE instruction is a load / a multiply
//   ex_dst                EXE destination register
//   mem_valid, mem_wen    MEM instruction valid / writes a register
//   mem_dst               MEM destination register
//   dcache_miss           MEM access is waiting on the data cache
//   stall_if..stall_mem   hold the corresponding stage register
//   bubble_ex, bubble_mem clear the valid bit written into EXE / MEM
//   byp_ex, byp_mem       per-operand forwarding selects (bypass_t)
//   mul_busy              the multiply sequencer is in its MUL state
//   stall_cycles          free-running count of cycles with stall_id high
// ============================================================================

package hazard_ctrl_pkg;

    // One select bit per DECODE operand.
    typedef struct packed {
        logic dep_src1;
        logic dep_src2;
    } bypass_t;

endpackage

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_FILE_LEN = 32,
    parameter int MUL_LAT      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            id_valid,
    input  logic [$clog2(REG_FILE_LEN)-1:0] id_src1,
    input  logic [$clog2(REG_FILE_LEN)-1:0] id_src2,
    input  logic                            id_uses_src2,

    input  logic                            ex_valid,
    input  logic                            ex_wen,
    input  logic                            ex_is_load,
    input  logic                            ex_is_mul,
    input  logic [$clog2(REG_FILE_LEN)-1:0] ex_dst,

    input  logic                            mem_valid,
    input  logic                            mem_wen,
    input  logic [$clog2(REG_FILE_LEN)-1:0] mem_dst,

    input  logic                            dcache_miss,

    output logic                            stall_if,
    output logic                            stall_id,
    output logic                            stall_ex,
    output logic                            stall_mem,
    output logic                            bubble_ex,
    output logic                            bubble_mem,
    output bypass_t                         byp_ex,
    output bypass_t                         byp_mem,
    output logic                            mul_busy,
    output logic [31:0]                     stall_cycles
);

    localparam int IDX_W = $clog2(REG_FILE_LEN);
    localparam int CNT_W = $clog2(MUL_LAT);

    // The first occupancy cycle is spent in IDLE, and the cycle with cnt==0
    // is the release cycle, so MUL is entered with MUL_LAT-2 remaining.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 2);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } mul_state_t;

    mul_state_t       state;
    mul_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             mul_stall;

    logic ex_m1;
    logic ex_m2;
    logic mem_m1;
    logic mem_m2;
    logic load_use;

    // Producer match terms. x0 is hard-wired to zero, so a write to it is
    // never a dependency; src2 only counts when the instruction reads it.
    assign ex_m1  = id_valid & ex_valid & ex_wen & (ex_dst != '0) & (ex_dst == id_src1);
    assign ex_m2  = id_valid & ex_valid & ex_wen & (ex_dst != '0) & (ex_dst == id_src2)
                    & id_uses_src2;
    assign mem_m1 = id_valid & mem_valid & mem_wen & (mem_dst != '0) & (mem_dst == id_src1);
    assign mem_m2 = id_valid & mem_valid & mem_wen & (mem_dst != '0) & (mem_dst == id_src2)
                    & id_uses_src2;

    // A load in EXE has no result yet, so a dependency on it cannot be
    // forwarded from EXE and must wait one cycle for the load to reach MEM.
    assign load_use = (ex_m1 | ex_m2) & ex_is_load;

    // Forwarding selects. The EXE producer is younger than the MEM one, so
    // a MEM forward is only used when EXE does not also match that operand.
    // These ignore stalls entirely.
    assign byp_ex.dep_src1  = ex_m1 & ~ex_is_load;
    assign byp_ex.dep_src2  = ex_m2 & ~ex_is_load;
    assign byp_mem.dep_src1 = mem_m1 & ~ex_m1;
    assign byp_mem.dep_src2 = mem_m2 & ~ex_m2;

    assign mul_busy = (state == MUL);

    // Multiply sequencer state register. Reset drops straight back to IDLE
    // even in the middle of a multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Multiply sequencer next-state logic. A multiply seen in IDLE stalls
    // immediately and moves to MUL; MUL keeps stalling while cnt counts
    // down, and the cnt==0 cycle lets the multiply leave EXE. A data-cache
    // miss freezes the whole pipeline, so the sequencer must not advance
    // either, otherwise the multiply would be released early.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mul_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid && ex_is_mul) begin
                    mul_stall  = 1'b1;
                    state_next = MUL;
                    cnt_next   = CNT_INIT;
                end
            end
            MUL: begin
                if (cnt != '0) begin
                    mul_stall = 1'b1;
                    cnt_next  = cnt - CNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (dcache_miss) begin
            state_next = state;
            cnt_next   = cnt;
        end
    end

    // Stall and bubble outputs in priority order: cache miss freezes every
    // stage with no bubbles, a multiply holds IF/ID/EX and feeds a bubble
    // into MEM, and a load-use hazard holds IF/ID and feeds a bubble into
    // EXE. The load-use bubble only appears when EXE itself is not held,
    // which the priority chain guarantees.
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        stall_mem  = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        if (dcache_miss) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (mul_stall) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // Performance counter of DECODE stall cycles; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_id) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for hazard_ctrl with the default parameters
// (32 registers, MUL_LAT=4). Inputs change 1 ns after each rising edge and
// outputs are compared 1 ns later, well away from the next edge.
// ============================================================================

module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_src1;
    logic [4:0]  id_src2;
    logic        id_uses_src2;
    logic        ex_valid;
    logic        ex_wen;
    logic        ex_is_load;
    logic        ex_is_mul;
    logic [4:0]  ex_dst;
    logic        mem_valid;
    logic        mem_wen;
    logic [4:0]  mem_dst;
    logic        dcache_miss;
    logic        stall_if;
    logic        stall_id;
    logic        stall_ex;
    logic        stall_mem;
    logic        bubble_ex;
    logic        bubble_mem;
    bypass_t     byp_ex;
    bypass_t     byp_mem;
    logic        mul_busy;
    logic [31:0] stall_cycles;

    int n_checks;
    int n_fails;

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem}
    logic [5:0] ctl;
    assign ctl = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem};

    localparam logic [5:0] CTL_NONE = 6'b000000;
    localparam logic [5:0] CTL_LOAD = 6'b110010;
    localparam logic [5:0] CTL_MUL  = 6'b111001;
    localparam logic [5:0] CTL_MISS = 6'b111100;

    hazard_ctrl #(
        .REG_FILE_LEN (32),
        .MUL_LAT      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src2 (id_uses_src2),
        .ex_valid     (ex_valid),
        .ex_wen       (ex_wen),
        .ex_is_load   (ex_is_load),
        .ex_is_mul    (ex_is_mul),
        .ex_dst       (ex_dst),
        .mem_valid    (mem_valid),
        .mem_wen      (mem_wen),
        .mem_dst      (mem_dst),
        .dcache_miss  (dcache_miss),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .stall_mem    (stall_mem),
        .bubble_ex    (bubble_ex),
        .bubble_mem   (bubble_mem),
        .byp_ex       (byp_ex),
        .byp_mem      (byp_mem),
        .mul_busy     (mul_busy),
        .stall_cycles (stall_cycles)
    );

    // 100 MHz core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to 1 ns past the next rising edge, where new inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive every DECODE/EXE/MEM input in one call.
    task automatic apply_stimulus(
        input logic       idv, input logic [4:0] s1, input logic [4:0] s2, input logic us2,
        input logic       exv, input logic exw, input logic exl, input logic exm,
        input logic [4:0] exd,
        input logic       memv, input logic memw, input logic [4:0] memd,
        input logic       miss
    );
        id_valid     = idv;
        id_src1      = s1;
        id_src2      = s2;
        id_uses_src2 = us2;
        ex_valid     = exv;
        ex_wen       = exw;
        ex_is_load   = exl;
        ex_is_mul    = exm;
        ex_dst       = exd;
        mem_valid    = memv;
        mem_wen      = memw;
        mem_dst      = memd;
        dcache_miss  = miss;
        #1;
    endtask

    // One comparison; the failure counter here feeds the summary line.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold reset for two edges with all inputs idle, then release.
    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Directed sequence: reset, bypass selection, load-use, multiply
    // sequencing, cache-miss freeze, and reset during a multiply.
    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        check_output("reset_ctl", 32'(ctl), 32'(CTL_NONE));
        check_output("reset_byp", 32'({byp_ex, byp_mem}), 32'd0);
        check_output("reset_busy", 32'(mul_busy), 32'd0);
        check_output("reset_cnt", stall_cycles, 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // EXE and MEM both write x5: EXE wins
        apply_stimulus(1, 5, 0, 0, 1, 1, 0, 0, 5, 1, 1, 5, 0);
        check_output("exmem_byp_ex", 32'(byp_ex), 32'b10);
        check_output("exmem_byp_mem", 32'(byp_mem), 32'b00);
        check_output("exmem_ctl", 32'(ctl), 32'(CTL_NONE));

        // Only MEM matches src1
        apply_stimulus(1, 5, 0, 0, 1, 1, 0, 0, 6, 1, 1, 5, 0);
        check_output("mem_only_ex", 32'(byp_ex), 32'b00);
        check_output("mem_only_mem", 32'(byp_mem), 32'b10);

        // src2 match ignored unless it is a register operand
        apply_stimulus(1, 9, 3, 0, 1, 1, 0, 0, 3, 0, 0, 0, 0);
        check_output("src2_unused", 32'(byp_ex), 32'b00);
        apply_stimulus(1, 9, 3, 1, 1, 1, 0, 0, 3, 0, 0, 0, 0);
        check_output("src2_used", 32'(byp_ex), 32'b01);

        // x0 destination never forwards
        apply_stimulus(1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        check_output("x0_byp", 32'({byp_ex, byp_mem}), 32'd0);

        // Invalid DECODE never forwards
        apply_stimulus(0, 5, 5, 1, 1, 1, 0, 0, 5, 1, 1, 5, 0);
        check_output("idinv_byp", 32'({byp_ex, byp_mem}), 32'd0);

        // MEM forwards src2 while EXE forwards src1
        apply_stimulus(1, 4, 8, 1, 1, 1, 0, 0, 4, 1, 1, 8, 0);
        check_output("split_byp", 32'({byp_ex, byp_mem}), 32'b1001);

        // Load-use on x7: one bubble, then MEM forwards
        apply_stimulus(1, 7, 0, 0, 1, 1, 1, 0, 7, 0, 0, 0, 0);
        check_output("lu_ctl", 32'(ctl), 32'(CTL_LOAD));
        check_output("lu_byp_ex", 32'(byp_ex), 32'b00);
        next_cycle();
        apply_stimulus(1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0);
        check_output("lu_after_ctl", 32'(ctl), 32'(CTL_NONE));
        check_output("lu_after_mem", 32'(byp_mem), 32'b10);
        check_output("lu_stall_cnt", stall_cycles, 32'd1);

        // Back-to-back multiplies: each stalls 3 cycles, busy 3 cycles
        do_reset();
        apply_stimulus(0, 0, 0, 0, 1, 1, 0, 1, 10, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("mul_busy_%0d", i), 32'(mul_busy),
                         32'((i % 4) != 0));
            check_output($sformatf("mul_ctl_%0d", i), 32'(ctl),
                         32'(((i % 4) != 3) ? CTL_MUL : CTL_NONE));
            next_cycle();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("mul_done_busy", 32'(mul_busy), 32'd0);
        check_output("mul_done_cnt", stall_cycles, 32'd6);

        // Five-cycle cache miss in the middle of a multiply
        do_reset();
        apply_stimulus(0, 0, 0, 0, 1, 1, 0, 1, 10, 0, 0, 0, 0);
        check_output("mm_c0_ctl", 32'(ctl), 32'(CTL_MUL));
        next_cycle();
        check_output("mm_c1_ctl", 32'(ctl), 32'(CTL_MUL));
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 1, 1, 0, 1, 10, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("mm_miss_ctl_%0d", i), 32'(ctl), 32'(CTL_MISS));
            check_output($sformatf("mm_miss_busy_%0d", i), 32'(mul_busy), 32'd1);
            next_cycle();
        end
        apply_stimulus(0, 0, 0, 0, 1, 1, 0, 1, 10, 0, 0, 0, 0);
        check_output("mm_resume_ctl", 32'(ctl), 32'(CTL_MUL));
        next_cycle();
        check_output("mm_release_ctl", 32'(ctl), 32'(CTL_NONE));
        check_output("mm_release_busy", 32'(mul_busy), 32'd1);
        check_output("mm_total_cnt", stall_cycles, 32'd8);

        // Miss landing on the release cycle: stays in MUL until it clears
        apply_stimulus(0, 0, 0, 0, 1, 1, 0, 1, 10, 0, 0, 0, 1);
        check_output("mz_miss_ctl", 32'(ctl), 32'(CTL_MISS));
        next_cycle();
        check_output("mz_hold_busy", 32'(mul_busy), 32'd1);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 1, 1, 0, 1, 10, 0, 0, 0, 0);
        check_output("mz_release_busy", 32'(mul_busy), 32'd1);
        check_output("mz_release_ctl", 32'(ctl), 32'(CTL_NONE));
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("mz_idle_busy", 32'(mul_busy), 32'd0);
        check_output("mz_total_cnt", stall_cycles, 32'd10);

        // Asynchronous reset in the middle of a multiply
        apply_stimulus(0, 0, 0, 0, 1, 1, 0, 1, 12, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        check_output("rst_pre_busy", 32'(mul_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_busy", 32'(mul_busy), 32'd0);
        check_output("rst_mid_cnt", stall_cycles, 32'd0);
        next_cycle();
        check_output("rst_held_cnt", stall_cycles, 32'd0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        next_cycle();
        check_output("rst_after_ctl", 32'(ctl), 32'(CTL_NONE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
